// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider.
// Used by div_unit, and by ex and ctrl for the stall request.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between EX and the divider.
// master = EX side, slave = divider side.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU, one bit per cycle.
// Returns {remainder, quotient}; EX stalls until ready_o.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    div_unit_if.slave   bus
);

    div_state_e             r_state;
    div_state_e             w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [2*WIDTH:0]       r_dividend;
    logic [2*WIDTH:0]       w_dividend_nxt;
    logic [WIDTH-1:0]       r_divisor;
    logic [WIDTH-1:0]       w_divisor_nxt;
    logic                   r_signed;
    logic                   w_signed_nxt;
    logic                   r_sign1;
    logic                   w_sign1_nxt;
    logic                   r_sign2;
    logic                   w_sign2_nxt;
    logic [2*WIDTH-1:0]     r_result;
    logic [2*WIDTH-1:0]     w_result_nxt;
    logic                   r_ready;
    logic                   w_ready_nxt;

    logic [WIDTH:0]         w_diff;
    logic [WIDTH-1:0]       w_op1_abs;
    logic [WIDTH-1:0]       w_op2_abs;
    logic [WIDTH-1:0]       w_quot;
    logic [WIDTH-1:0]       w_rem;
    logic                   w_go;
    logic                   w_last;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH);

    // A start is only honoured when not being flushed at the same edge.
    assign w_go   = (bus.start_i == DivStart) && !bus.annul_i;
    assign w_last = (r_cnt == LastCnt);

    // Magnitudes of the operands; only signed requests take abs().
    assign w_op1_abs = (bus.signed_div_i && bus.opdata1_i[WIDTH-1])
                     ? -bus.opdata1_i : bus.opdata1_i;
    assign w_op2_abs = (bus.signed_div_i && bus.opdata2_i[WIDTH-1])
                     ? -bus.opdata2_i : bus.opdata2_i;

    // Trial subtract; bit WIDTH set means the partial remainder is short.
    assign w_diff = {1'b0, r_dividend[2*WIDTH-1:WIDTH]}
                  - {1'b0, r_divisor};

    // Sign fix-up: quotient follows sign xor, remainder follows dividend.
    assign w_quot = (r_signed && (r_sign1 ^ r_sign2))
                  ? -r_dividend[WIDTH-1:0] : r_dividend[WIDTH-1:0];
    assign w_rem  = (r_signed && r_sign1)
                  ? -r_dividend[2*WIDTH:WIDTH+1]
                  : r_dividend[2*WIDTH:WIDTH+1];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= DivFree;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            DivFree: begin
                if (w_go)
                    w_state_nxt = (bus.opdata2_i == '0) ? DivByZero : DivOn;
            end
            DivByZero: w_state_nxt = DivEnd;
            DivOn: begin
                if (bus.annul_i)  w_state_nxt = DivFree;
                else if (w_last)  w_state_nxt = DivEnd;
            end
            DivEnd: begin
                if (bus.start_i == DivStop) w_state_nxt = DivFree;
            end
            default: w_state_nxt = DivFree;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_dividend_nxt = r_dividend;
        w_divisor_nxt  = r_divisor;
        w_signed_nxt   = r_signed;
        w_sign1_nxt    = r_sign1;
        w_sign2_nxt    = r_sign2;
        w_result_nxt   = r_result;
        w_ready_nxt    = r_ready;
        unique case (r_state)
            DivFree: begin
                w_result_nxt = '0;
                w_ready_nxt  = DivResultNotReady;
                if (w_go && bus.opdata2_i != '0) begin
                    w_dividend_nxt = {{WIDTH{1'b0}}, w_op1_abs, 1'b0};
                    w_divisor_nxt  = w_op2_abs;
                    w_signed_nxt   = bus.signed_div_i;
                    w_sign1_nxt    = bus.opdata1_i[WIDTH-1];
                    w_sign2_nxt    = bus.opdata2_i[WIDTH-1];
                    w_cnt_nxt      = '0;
                end
            end
            DivByZero: begin
                w_result_nxt = '0;
                w_ready_nxt  = DivResultReady;
            end
            DivOn: begin
                if (bus.annul_i) begin
                    w_cnt_nxt    = '0;
                    w_result_nxt = '0;
                    w_ready_nxt  = DivResultNotReady;
                end else if (w_last) begin
                    w_cnt_nxt    = '0;
                    w_result_nxt = {w_rem, w_quot};
                    w_ready_nxt  = DivResultReady;
                end else begin
                    if (w_diff[WIDTH])
                        w_dividend_nxt = {r_dividend[2*WIDTH-1:0], 1'b0};
                    else
                        w_dividend_nxt = {w_diff[WIDTH-1:0],
                                          r_dividend[WIDTH-1:0], 1'b1};
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DivEnd: begin
                if (bus.start_i == DivStop) begin
                    w_result_nxt = '0;
                    w_ready_nxt  = DivResultNotReady;
                end
            end
            default: begin
                w_result_nxt = '0;
                w_ready_nxt  = DivResultNotReady;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_signed   <= 1'b0;
            r_sign1    <= 1'b0;
            r_sign2    <= 1'b0;
            r_result   <= '0;
            r_ready    <= DivResultNotReady;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_dividend <= w_dividend_nxt;
            r_divisor  <= w_divisor_nxt;
            r_signed   <= w_signed_nxt;
            r_sign1    <= w_sign1_nxt;
            r_sign2    <= w_sign2_nxt;
            r_result   <= w_result_nxt;
            r_ready    <= w_ready_nxt;
        end
    end

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit.
// Drives 1 ns after each rising edge, samples there too.
module tb_div_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
    endtask

    // Issue a request and count edges until ready_o (bounded at 40).
    // With scramble set, operands change after the start edge.
    task automatic do_div(input logic s, input logic [31:0] a,
                          input logic [31:0] b, input bit scramble,
                          output int n, output logic [63:0] res);
        bus.signed_div_i = s;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (scramble && n == 1) begin
                bus.signed_div_i = ~s;
                bus.opdata1_i    = 32'h5;
                bus.opdata2_i    = 32'h1;
            end
        end while (!bus.ready_o && n < 40);
        res = bus.result_o;
    endtask

    task automatic release_start();
        bus.start_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            errors++;
            $display("FAIL reset: ready=%b result=%h want 0/0",
                     bus.ready_o, bus.result_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unsigned();
        int n;
        logic [63:0] res;
        do_div(1'b0, 32'd100, 32'd7, 1'b0, n, res);
        checks++;
        if (n !== 34) begin
            errors++;
            $display("FAIL udiv_latency: edges=%0d want 34", n);
        end
        checks++;
        if (res !== {32'd2, 32'd14}) begin
            errors++;
            $display("FAIL udiv_100_7: got %h want %h",
                     res, {32'd2, 32'd14});
        end
        release_start();
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            errors++;
            $display("FAIL udiv_release: ready=%b result=%h want 0/0",
                     bus.ready_o, bus.result_o);
        end
    endtask

    task automatic test_vectors();
        logic        s  [4];
        logic [31:0] a  [4];
        logic [31:0] b  [4];
        logic [63:0] ex [4];
        int n;
        logic [63:0] res;
        s[0] = 1'b1; a[0] = 32'hFFFFFFF9; b[0] = 32'd2;
        ex[0] = {32'hFFFFFFFF, 32'hFFFFFFFD};
        s[1] = 1'b1; a[1] = 32'h80000000; b[1] = 32'hFFFFFFFF;
        ex[1] = {32'h00000000, 32'h80000000};
        s[2] = 1'b1; a[2] = 32'd7; b[2] = 32'hFFFFFFFE;
        ex[2] = {32'd1, 32'hFFFFFFFD};
        s[3] = 1'b0; a[3] = 32'hFFFFFFFE; b[3] = 32'hFFFFFFFF;
        ex[3] = {32'hFFFFFFFE, 32'd0};
        for (int i = 0; i < 4; i++) begin
            do_div(s[i], a[i], b[i], 1'b0, n, res);
            checks++;
            if (n !== 34 || res !== ex[i]) begin
                errors++;
                $display("FAIL vec%0d: edges=%0d res=%h want 34 %h",
                         i, n, res, ex[i]);
            end
            release_start();
        end
    endtask

    task automatic test_div_zero();
        int n;
        logic [63:0] res;
        do_div(1'b0, 32'h12345678, 32'd0, 1'b0, n, res);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL divzero_latency: edges=%0d want 2", n);
        end
        checks++;
        if (res !== 64'd0) begin
            errors++;
            $display("FAIL divzero_result: got %h want 0", res);
        end
        release_start();
    endtask

    task automatic test_annul();
        int n;
        logic [63:0] res;
        bit rose;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) tick();
        bus.annul_i = 1'b1;
        tick();
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        rose = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.ready_o !== 1'b0) rose = 1'b1;
            tick();
        end
        checks++;
        if (rose) begin
            errors++;
            $display("FAIL annul_ready: ready rose=1 want 0");
        end
        do_div(1'b0, 32'hFFFFFFFF, 32'd1, 1'b0, n, res);
        checks++;
        if (n !== 34 || res !== {32'd0, 32'hFFFFFFFF}) begin
            errors++;
            $display("FAIL annul_reuse: edges=%0d res=%h want 34 %h",
                     n, res, {32'd0, 32'hFFFFFFFF});
        end
        release_start();
    endtask

    task automatic test_hold();
        int n;
        logic [63:0] res;
        bit moved;
        do_div(1'b0, 32'd100, 32'd7, 1'b1, n, res);
        checks++;
        if (n !== 34 || res !== {32'd2, 32'd14}) begin
            errors++;
            $display("FAIL latch_ops: edges=%0d res=%h want 34 %h",
                     n, res, {32'd2, 32'd14});
        end
        bus.annul_i   = 1'b1;
        bus.opdata2_i = 32'd0;
        moved = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.ready_o !== 1'b1 || bus.result_o !== {32'd2, 32'd14})
                moved = 1'b1;
        end
        checks++;
        if (moved) begin
            errors++;
            $display("FAIL hold_stable: ready=%b result=%h want 1 %h",
                     bus.ready_o, bus.result_o, {32'd2, 32'd14});
        end
        bus.annul_i = 1'b0;
        release_start();
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            errors++;
            $display("FAIL hold_release: ready=%b result=%h want 0/0",
                     bus.ready_o, bus.result_o);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        logic [63:0] res;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        tick();
        for (int i = 0; i < 19; i++) tick();
        rst = 1'b1;
        bus.start_i = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            errors++;
            $display("FAIL mid_reset: ready=%b result=%h want 0/0",
                     bus.ready_o, bus.result_o);
        end
        do_div(1'b0, 32'd9, 32'd3, 1'b0, n, res);
        checks++;
        if (n !== 34 || res !== {32'd0, 32'd3}) begin
            errors++;
            $display("FAIL after_reset: edges=%0d res=%h want 34 %h",
                     n, res, {32'd0, 32'd3});
        end
        release_start();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_unsigned();
        test_vectors();
        test_div_zero();
        test_annul();
        test_hold();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit restoring divider beside the execute stage.
- EX forwards the DIV/DIVU operands and a start request; this block returns {remainder, quotient} for the HI/LO write.
- EX holds the pipeline stalled until ready_o is high.
- One division in flight at a time; a flush (annul) cancels it.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- signed_div_i  input  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  input  32  dividend
- opdata2_i  input  32  divisor
- start_i  input  1  request; held high by EX until ready_o is seen
- annul_i  input  1  cancel the in-flight division (pipeline flush)
- result_o  output  64  {remainder[63:32], quotient[31:0]}, registered
- ready_o  output  1  result valid, registered

Behaviour:
- Reset (rst=1 at an edge):
  - state=DIV_FREE, cnt=0, working register cleared.
  - result_o=0, ready_o=0.
  - Reset wins over every other input, including mid-division.
- States:
  - DIV_FREE: idle, outputs 0.
    - Edge with start_i=1, annul_i=0, opdata2_i==0 -> DIV_BY_ZERO.
    - Edge with start_i=1, annul_i=0, opdata2_i!=0 -> DIV_ON.
    - Start with annul_i=1 is ignored.
  - On entry to DIV_ON, latch the operands:
    - If signed_div_i and an operand is negative, latch its two's-complement magnitude.
    - Latch signed_div_i and both original sign bits.
    - dividend register (65b) = {32'b0, |op1|, 1'b0}; cnt=0.
    - Later changes on opdata*/signed_div_i are ignored.
  - DIV_BY_ZERO: next edge -> DIV_END with the working result = 0.
  - DIV_ON, annul_i=1 at an edge -> DIV_FREE, cnt=0, ready_o stays 0.
  - DIV_ON, cnt<32, one iteration per edge:
    - diff = dividend[63:32] - |divisor| (33-bit).
    - If diff is negative: dividend <<= 1.
    - Else: dividend = {diff[31:0], dividend[31:0], 1'b1}.
    - cnt++.
  - DIV_ON, cnt==32 at an edge:
    - quotient = dividend[31:0]; negate it if signed and the sign bits differ.
    - remainder = dividend[64:33]; negate it if signed and the dividend was negative.
    - result_o loaded; ready_o=1; -> DIV_END; cnt=0.
  - DIV_END:
    - result_o and ready_o held stable while start_i=1.
    - Edge with start_i=0 -> DIV_FREE; result_o=0, ready_o=0.
    - annul_i has no effect here.
- Latency:
  - Start sampled at edge N -> ready_o high after edge N+33.
  - Divide-by-zero: ready_o high after edge N+1.
- Arithmetic:
  - All wrap modulo 2^32.
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, with no trap.
  - Divide-by-zero result is architecturally undefined; this block returns 0.
- No back-to-back starts: start_i must drop for at least one cycle after ready_o before the next request.

Decomposition:
- Shared defines file:
  - State encodings DivFree, DivByZero, DivOn, DivEnd (2-bit).
  - DivResultReady / DivResultNotReady.
  - DivStart / DivStop.
- These are shared with ex and ctrl (stall request).
- Single module; no sub-module is warranted.
- The 33-bit subtract stays inline.

Test Plan:
- Unsigned 100/7, start at edge N:
  - ready_o=0 through edge N+32.
  - ready_o=1 after N+33.
  - result_o = {32'd2, 32'd14}.
- Signed -7 (0xFFFFFFF9) / 2:
  - result_o = {0xFFFFFFFF, 0xFFFFFFFD}, i.e. r=-1, q=-3.
- Divisor 0, dividend 0x12345678:
  - ready_o=1 after edge N+1.
  - result_o = 0.
- Annul, then reuse:
  - annul_i=1 on the 10th DIV_ON edge -> ready_o never rises; state idle next cycle.
  - New unsigned 0xFFFFFFFF/1 -> result_o = {0, 0xFFFFFFFF} after 33 edges.
- Signed 0x80000000 / 0xFFFFFFFF:
  - result_o = {0x00000000, 0x80000000}.
- Handshake hold and mid-run reset:
  - Hold start_i 5 cycles in DIV_END -> outputs stable; drop start_i -> next cycle ready_o=0, result_o=0.
  - Separately, assert rst on the 20th iteration -> outputs 0 next cycle, and a fresh 9/3 returns {0, 3} with full latency.
